// File: rtl/adder_chain_sequencer_if.sv
// Bus bundle between the adder chain sequencer and its surroundings:
// the serial operand input stream, the operand/sum connection to the
// adder chain, and the result output stream.
//
// Handshake rule for both streams: a beat transfers on a rising clk edge
// where valid && ready are both high. The producer keeps valid and its data
// stable until that edge. The consumer may raise or lower ready freely, and
// ready never waits for valid.
interface adder_chain_sequencer_if #(
    parameter int bit_width = 8
) ();
    logic                 in_valid;
    logic                 in_ready;
    logic [bit_width-1:0] in_data;
    logic [bit_width-1:0] chain_a;
    logic [bit_width-1:0] chain_b;
    logic [bit_width-1:0] chain_c;
    logic [bit_width-1:0] chain_sum;
    logic                 out_valid;
    logic                 out_ready;
    logic [bit_width-1:0] out_sum;

    // Sequencer side
    modport master (
        input  in_valid, in_data, chain_sum, out_ready,
        output in_ready, chain_a, chain_b, chain_c, out_valid, out_sum
    );

    // Environment side: operand source, adder chain and result consumer
    modport slave (
        output in_valid, in_data, chain_sum, out_ready,
        input  in_ready, chain_a, chain_b, chain_c, out_valid, out_sum
    );
endinterface

// File: rtl/adder_chain_sequencer.sv
// Adder chain sequencer. It collects operands a, b and c serially from one
// input stream and holds them on the chain inputs. It then waits
// settle_cycles for the combinational chain to resolve, captures the sum,
// and offers that sum on the output stream until the consumer takes it.
module adder_chain_sequencer #(
    parameter int bit_width     = 8,
    parameter int settle_cycles = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    adder_chain_sequencer_if.master bus,
    output logic                   busy,
    output logic [2:0]             state_dbg
);

    // A settle time of zero would sample the chain in the same cycle that c
    // is loaded, before the chain has seen it.
    if (settle_cycles < 1) begin : g_bad_settle
        $error("adder_chain_sequencer: settle_cycles must be >= 1");
    end

    localparam int CW = $clog2(settle_cycles + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(settle_cycles - 1);

    typedef enum logic [2:0] {
        LOAD_A = 3'd0,
        LOAD_B = 3'd1,
        LOAD_C = 3'd2,
        SETTLE = 3'd3,
        HOLD   = 3'd4
    } state_t;

    state_t               state_q;
    logic [CW-1:0]        cnt_q;
    logic [bit_width-1:0] a_q;
    logic [bit_width-1:0] b_q;
    logic [bit_width-1:0] c_q;
    logic [bit_width-1:0] sum_q;
    logic                 out_valid_q;
    logic                 in_ready_w;

    // Operands are only taken in the three load states, whatever in_valid does
    assign in_ready_w = (state_q == LOAD_A) || (state_q == LOAD_B) || (state_q == LOAD_C);

    // Sequencer FSM: load a/b/c, count settle cycles, capture, hold for consumer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= LOAD_A;
            cnt_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            c_q         <= '0;
            sum_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                LOAD_A: begin
                    if (bus.in_valid && in_ready_w) begin
                        a_q     <= bus.in_data;
                        state_q <= LOAD_B;
                    end
                end
                LOAD_B: begin
                    if (bus.in_valid && in_ready_w) begin
                        b_q     <= bus.in_data;
                        state_q <= LOAD_C;
                    end
                end
                LOAD_C: begin
                    if (bus.in_valid && in_ready_w) begin
                        c_q     <= bus.in_data;
                        cnt_q   <= '0;
                        state_q <= SETTLE;
                    end
                end
                SETTLE: begin
                    // Capture on the last settle edge. The counter stops there,
                    // so it never wraps.
                    if (cnt_q == CNT_LAST) begin
                        sum_q       <= bus.chain_sum;
                        out_valid_q <= 1'b1;
                        state_q     <= HOLD;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                HOLD: begin
                    if (out_valid_q && bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= LOAD_A;
                    end
                end
                default: begin
                    state_q <= LOAD_A;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_w;
    assign bus.chain_a   = a_q;
    assign bus.chain_b   = b_q;
    assign bus.chain_c   = c_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_sum   = sum_q;
    assign busy          = (state_q != LOAD_A);
    assign state_dbg     = state_q;

endmodule

// File: tb/tb_adder_chain_sequencer.sv
// Directed bench for adder_chain_sequencer. Three instances run side by side
// with settle_cycles of 2, 1 and 5. Each instance gets a bench-side model of
// the adder chain. The settle=5 model can be overridden to alter chain_sum
// while the instance is settling.
module tb_adder_chain_sequencer;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  logic       ovr_en;
  logic [7:0] ovr_val;

  logic       busy2, busy1, busy5;
  logic [2:0] st2, st1, st5;

  adder_chain_sequencer_if #(.bit_width(8)) bus2 ();
  adder_chain_sequencer_if #(.bit_width(8)) bus1 ();
  adder_chain_sequencer_if #(.bit_width(8)) bus5 ();

  // Adder chain models: plain 8-bit sum of the presented operands
  assign bus2.chain_sum = bus2.chain_a + bus2.chain_b + bus2.chain_c;
  assign bus1.chain_sum = bus1.chain_a + bus1.chain_b + bus1.chain_c;
  assign bus5.chain_sum = ovr_en ? ovr_val : (bus5.chain_a + bus5.chain_b + bus5.chain_c);

  adder_chain_sequencer #(.bit_width(8), .settle_cycles(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(bus2), .busy(busy2), .state_dbg(st2)
  );
  adder_chain_sequencer #(.bit_width(8), .settle_cycles(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1), .busy(busy1), .state_dbg(st1)
  );
  adder_chain_sequencer #(.bit_width(8), .settle_cycles(5)) dut5 (
    .clk(clk), .rst_n(rst_n), .bus(bus5), .busy(busy5), .state_dbg(st5)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 time unit past it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Directed stimulus
  initial begin
    checks   = 0;
    failures = 0;
    ovr_en   = 1'b0;
    ovr_val  = 8'd0;
    rst_n    = 1'b0;
    bus2.in_valid = 1'b0; bus2.in_data = 8'd0; bus2.out_ready = 1'b1;
    bus1.in_valid = 1'b0; bus1.in_data = 8'd0; bus1.out_ready = 1'b1;
    bus5.in_valid = 1'b0; bus5.in_data = 8'd0; bus5.out_ready = 1'b0;

    // ---- reset state
    tick();
    tick();
    check("rst_in_ready", bus2.in_ready, 1);
    check("rst_busy", busy2, 0);
    check("rst_out_valid", bus2.out_valid, 0);
    check("rst_out_sum", bus2.out_sum, 0);
    check("rst_chain_a", bus2.chain_a, 0);
    check("rst_chain_c", bus2.chain_c, 0);
    rst_n = 1'b1;

    // ---- basic: 3, 5, 7 on consecutive cycles
    bus2.in_valid = 1'b1; bus2.in_data = 8'd3; tick();
    check("basic_busy_after_a", busy2, 1);
    bus2.in_data = 8'd5; tick();
    bus2.in_data = 8'd7; tick();          // c accepted here (edge k)
    bus2.in_valid = 1'b0;
    check("basic_chain_a", bus2.chain_a, 3);
    check("basic_chain_b", bus2.chain_b, 5);
    check("basic_chain_c", bus2.chain_c, 7);
    check("basic_in_ready_settle", bus2.in_ready, 0);
    check("basic_ov_k", bus2.out_valid, 0);
    tick();                               // k+1
    check("basic_ov_k1", bus2.out_valid, 0);
    tick();                               // k+2
    check("basic_ov_k2", bus2.out_valid, 1);
    check("basic_sum", bus2.out_sum, 15);
    tick();                               // handshake edge
    check("basic_ov_after_hs", bus2.out_valid, 0);
    check("basic_busy_after_hs", busy2, 0);
    check("basic_in_ready_after_hs", bus2.in_ready, 1);

    // ---- wrap: 200 + 100 + 10 = 310 -> 54
    bus2.in_valid = 1'b1; bus2.in_data = 8'd200; tick();
    bus2.in_data = 8'd100; tick();
    bus2.in_data = 8'd10; tick();
    bus2.in_valid = 1'b0;
    tick();
    tick();
    check("wrap_ov", bus2.out_valid, 1);
    check("wrap_sum", bus2.out_sum, 54);
    tick();
    check("wrap_back_idle", busy2, 0);

    // ---- backpressure: 1 + 2 + 3 = 6, consumer stalls for 5 cycles
    bus2.out_ready = 1'b0;
    bus2.in_valid = 1'b1; bus2.in_data = 8'd1; tick();
    bus2.in_data = 8'd2; tick();
    bus2.in_data = 8'd3; tick();
    bus2.in_data = 8'd9;                  // upstream keeps offering 9
    tick();
    tick();
    check("bp_ov", bus2.out_valid, 1);
    check("bp_sum", bus2.out_sum, 6);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_in_ready_hold", bus2.in_ready, 0);
      check("bp_ov_hold", bus2.out_valid, 1);
      check("bp_sum_hold", bus2.out_sum, 6);
      check("bp_a_not_taken", bus2.chain_a, 1);
    end
    bus2.out_ready = 1'b1;
    tick();                               // handshake edge, 9 not yet taken
    check("bp_ov_drop", bus2.out_valid, 0);
    check("bp_no_passthru", bus2.chain_a, 1);
    check("bp_idle", busy2, 0);
    tick();                               // 9 taken as a
    check("bp_a_taken", bus2.chain_a, 9);
    check("bp_busy", busy2, 1);
    bus2.in_data = 8'd1; tick();
    bus2.in_data = 8'd1; tick();
    bus2.in_valid = 1'b0;
    tick();
    tick();
    check("bp_second_sum", bus2.out_sum, 11);
    tick();

    // ---- input gaps: valid pattern 1,0,0,1,0,1 with data 1,x,x,2,x,4
    bus2.in_valid = 1'b1; bus2.in_data = 8'd1;   tick();
    bus2.in_valid = 1'b0; bus2.in_data = 8'hAA;  tick();
    bus2.in_valid = 1'b0; bus2.in_data = 8'hAA;  tick();
    check("gap_still_load_b", bus2.in_ready, 1);
    bus2.in_valid = 1'b1; bus2.in_data = 8'd2;   tick();
    bus2.in_valid = 1'b0; bus2.in_data = 8'hAA;  tick();
    check("gap_b_hold", bus2.chain_b, 2);
    bus2.in_valid = 1'b1; bus2.in_data = 8'd4;   tick();
    bus2.in_valid = 1'b0;
    check("gap_chain_a", bus2.chain_a, 1);
    check("gap_chain_c", bus2.chain_c, 4);
    tick();
    tick();
    check("gap_sum", bus2.out_sum, 7);
    tick();

    // ---- settle_cycles = 1: 10 + 20 + 30 = 60, valid at k+1
    bus1.in_valid = 1'b1; bus1.in_data = 8'd10; tick();
    bus1.in_data = 8'd20; tick();
    bus1.in_data = 8'd30; tick();
    bus1.in_valid = 1'b0;
    check("s1_ov_k", bus1.out_valid, 0);
    tick();
    check("s1_ov_k1", bus1.out_valid, 1);
    check("s1_sum", bus1.out_sum, 60);
    tick();
    check("s1_idle", busy1, 0);

    // ---- settle_cycles = 5 with chain_sum changed while settling
    bus5.in_valid = 1'b1; bus5.in_data = 8'd1; tick();
    bus5.in_data = 8'd2; tick();
    bus5.in_data = 8'd3; tick();          // edge k
    bus5.in_valid = 1'b0;
    tick();
    tick();                               // k+2
    ovr_en = 1'b1; ovr_val = 8'h55;
    tick();                               // k+3
    tick();                               // k+4
    check("s5_ov_k4", bus5.out_valid, 0);
    ovr_val = 8'h77;
    tick();                               // k+5 capture
    check("s5_ov_k5", bus5.out_valid, 1);
    check("s5_sum_capture_edge", bus5.out_sum, 8'h77);
    ovr_val = 8'h11;
    tick();
    check("s5_sum_stable", bus5.out_sum, 8'h77);
    bus5.out_ready = 1'b1;
    tick();
    check("s5_ov_drop", bus5.out_valid, 0);

    // ---- async reset in the middle of SETTLE
    bus2.in_valid = 1'b1; bus2.in_data = 8'd5; tick();
    bus2.in_data = 8'd6; tick();
    bus2.in_data = 8'd7; tick();          // now settling, out_sum still 7
    bus2.in_valid = 1'b0;
    check("mid_sum_before_rst", bus2.out_sum, 7);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_out_sum", bus2.out_sum, 0);
    check("mid_rst_out_valid", bus2.out_valid, 0);
    check("mid_rst_chain_a", bus2.chain_a, 0);
    check("mid_rst_busy", busy2, 0);
    check("mid_rst_in_ready", bus2.in_ready, 1);
    #1 rst_n = 1'b1;
    tick();
    check("mid_rst_idle", busy2, 0);
    bus2.in_valid = 1'b1; bus2.in_data = 8'd2; tick();
    bus2.in_data = 8'd3; tick();
    bus2.in_data = 8'd4; tick();
    bus2.in_valid = 1'b0;
    tick();
    check("fresh_ov_k1", bus2.out_valid, 0);
    tick();
    check("fresh_ov", bus2.out_valid, 1);
    check("fresh_sum", bus2.out_sum, 9);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/adder_chain_sequencer.md
Name: adder_chain_sequencer

Overview:
Upstream/downstream wrapper stage for the three-operand adder chain. It accepts the three operands a, b, c serially over one valid/ready input stream and holds them stable on the chain's inputs. It waits a fixed settle time for the chain's combinational result to propagate, then captures the chain's sum. The captured sum is presented on a valid/ready output stream, which lets a single narrow bus drive the chain and lets slow chain propagation be covered by a known cycle count.

Parameters:
bit_width, 8, width of every operand and of the sum
settle_cycles, 2, cycles operands are held on the chain before sum is sampled; legal range >= 1, 0 is illegal (elaboration-time assertion)

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  in_data carries an operand
in_ready  output  1  sequencer can accept an operand this cycle
in_data  input  bit_width  operand beat; order is a, then b, then c
chain_a  output  bit_width  registered operand a to the adder chain
chain_b  output  bit_width  registered operand b to the adder chain
chain_c  output  bit_width  registered operand c to the adder chain
chain_sum  input  bit_width  combinational sum returned by the adder chain
out_valid  output  1  out_sum holds a captured result
out_ready  input  1  consumer accepts out_sum
out_sum  output  bit_width  captured result
busy  output  1  high in any state other than LOAD_A

Behaviour:
- Reset (async, rst_n low): state=LOAD_A, chain_a/b/c=0, out_sum=0, out_valid=0, settle counter=0. The FSM leaves reset on the first rising clk edge after rst_n deasserts. Reset mid-operation discards any partial operands and any pending result.
- States: LOAD_A, LOAD_B, LOAD_C, SETTLE, HOLD.
- in_ready=1 exactly in LOAD_A/LOAD_B/LOAD_C; in_ready=0 in SETTLE and HOLD. It is a pure function of state and does not depend on in_valid.
- Input beat accepted on an edge where in_valid && in_ready:
  - LOAD_A: chain_a<=in_data, go to LOAD_B.
  - LOAD_B: chain_b<=in_data, go to LOAD_C.
  - LOAD_C: chain_c<=in_data, counter<=0, go to SETTLE.
- No accept: state and registers hold. in_valid gaps between beats are allowed indefinitely.
- SETTLE: counter increments each cycle. On the edge where counter==settle_cycles-1, out_sum<=chain_sum, out_valid<=1, go to HOLD.
- Counter width is $clog2(settle_cycles+1) and the counter never wraps.
- Latency: if c is accepted at edge k, out_valid is high from edge k+settle_cycles onward.
- HOLD: out_valid=1 and out_sum stable until out_valid && out_ready at an edge. At that edge, out_valid<=0 and state goes to LOAD_A. The earliest next a beat is accepted on the following edge, so there is no same-cycle pass-through.
- chain_a/b/c keep their values after capture and are only overwritten by new beats. chain_sum is ignored outside the capture edge.
- Arithmetic: none internal. out_sum is the chain's bit_width-bit result, i.e. (a+b+c) mod 2^bit_width. No carry-out is reported.
- out_ready high while out_valid=0 has no effect. in_valid high in SETTLE/HOLD has no effect; upstream must hold the beat.
- busy = (state != LOAD_A).

Test Plan:
- Basic, bit_width=8, settle_cycles=2, out_ready tied 1: beats 3, 5, 7 on consecutive cycles -> chain_a/b/c=3/5/7; out_valid high exactly 2 cycles after c accepted; out_sum=15; back to LOAD_A next cycle with busy=0.
- Wrap: beats 200, 100, 10 -> out_sum=54 (310 mod 256); no other flag changes.
- Backpressure: out_ready=0 for 5 cycles after out_valid, in_valid held 1 with data 9 -> in_ready stays 0; out_sum stays stable; the 9 is not accepted until the cycle after the out_ready handshake.
- Input gaps: in_valid toggles 1,0,0,1,0,1 with data 1, x, x, 2, x, 4 -> only valid beats are latched; result is 7.
- settle_cycles=1 and settle_cycles=5: c accepted at edge k -> out_valid rises at edge k+1 and k+5 respectively. A bench model that changes chain_sum mid-SETTLE shows the value present on the capture edge is the one latched.
- Reset mid-SETTLE: assert rst_n low asynchronously between edges -> all outputs 0 immediately, in_ready=1 after release; the next three beats form a fresh operation.
